// File: rtl/input_shift_register.sv
// rtl/input_shift_register.sv - input shift register with push buffer, RX FIFO handshake and optional autopush (ISR_AUTOPUSH_EN)
module input_shift_register (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        in_en,
    input  logic [5:0]  in_count,
    input  logic        shiftdir,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        push_req,
    input  logic        push_block,
    input  logic        autopush,
    input  logic [5:0]  push_thresh,
    output logic [31:0] isr,
    output logic [5:0]  isr_count,
    output logic [31:0] fifo_wdata,
    output logic        fifo_wvalid,
    input  logic        fifo_wready,
    output logic        stall,
    output logic        push_dropped
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PUSH = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] isr_nxt, push_buf, push_buf_nxt;
    logic [5:0]  count_nxt;
    logic        dropped_nxt;

    logic [5:0]  shift_n;
    logic [31:0] shifted;
    logic [6:0]  count_sum;
    logic [5:0]  count_sat;

    // A count of 0 or anything above 32 means a full 32-bit shift.
    assign shift_n = (in_count == 6'd0 || in_count > 6'd32) ? 6'd32 : in_count;

    always_comb begin
        shifted = data_in;
        if (shift_n != 6'd32) begin
            if (shiftdir)
                shifted = (isr >> shift_n) | (data_in << (6'd32 - shift_n));
            else
                shifted = (isr << shift_n) | (data_in & ((32'h1 << shift_n) - 32'h1));
        end
    end

    assign count_sum = {1'b0, isr_count} + {1'b0, shift_n};
    assign count_sat = (count_sum > 7'd32) ? 6'd32 : count_sum[5:0];

`ifdef ISR_AUTOPUSH_EN
    logic [5:0] thresh;
    logic       autopush_hit;
    assign thresh       = (push_thresh == 6'd0 || push_thresh > 6'd32) ? 6'd32 : push_thresh;
    assign autopush_hit = autopush && (count_sat >= thresh);
`else
    logic unused_autopush_inputs;
    logic autopush_hit;
    assign unused_autopush_inputs = ^{autopush, push_thresh};
    assign autopush_hit           = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        isr_nxt      = isr;
        count_nxt    = isr_count;
        push_buf_nxt = push_buf;
        dropped_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    isr_nxt   = load_data;
                    count_nxt = 6'd0;
                end else if (push_req) begin
                    isr_nxt   = 32'd0;
                    count_nxt = 6'd0;
                    if (push_block || fifo_wready) begin
                        push_buf_nxt = isr;
                        state_nxt    = ST_PUSH;
                    end else begin
                        dropped_nxt = 1'b1;
                    end
                end else if (in_en) begin
                    if (autopush_hit) begin
                        push_buf_nxt = shifted;
                        isr_nxt      = 32'd0;
                        count_nxt    = 6'd0;
                        state_nxt    = ST_PUSH;
                    end else begin
                        isr_nxt   = shifted;
                        count_nxt = count_sat;
                    end
                end
            end
            ST_PUSH: begin
                // Commands are ignored until the FIFO accepts the word.
                if (fifo_wready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            isr          <= 32'd0;
            isr_count    <= 6'd0;
            push_buf     <= 32'd0;
            push_dropped <= 1'b0;
        end else begin
            state        <= state_nxt;
            isr          <= isr_nxt;
            isr_count    <= count_nxt;
            push_buf     <= push_buf_nxt;
            push_dropped <= dropped_nxt;
        end
    end

    // The push buffer only changes when a push is taken, so it also holds the last word in IDLE.
    assign fifo_wdata  = push_buf;
    assign fifo_wvalid = (state == ST_PUSH);
    assign stall       = (state == ST_PUSH);

endmodule

// File: tb/tb_input_shift_register.sv
// tb/tb_input_shift_register.sv - directed scoreboard bench for input_shift_register
module tb_input_shift_register;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        in_en;
    logic [5:0]  in_count;
    logic        shiftdir;
    logic        load;
    logic [31:0] load_data;
    logic        push_req;
    logic        push_block;
    logic        autopush;
    logic [5:0]  push_thresh;
    logic [31:0] isr;
    logic [5:0]  isr_count;
    logic [31:0] fifo_wdata;
    logic        fifo_wvalid;
    logic        fifo_wready;
    logic        stall;
    logic        push_dropped;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    input_shift_register dut (
        .clk(clk), .rst(rst), .data_in(data_in), .in_en(in_en), .in_count(in_count),
        .shiftdir(shiftdir), .load(load), .load_data(load_data), .push_req(push_req),
        .push_block(push_block), .autopush(autopush), .push_thresh(push_thresh),
        .isr(isr), .isr_count(isr_count), .fifo_wdata(fifo_wdata), .fifo_wvalid(fifo_wvalid),
        .fifo_wready(fifo_wready), .stall(stall), .push_dropped(push_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Any handshake visible before the edge is a FIFO write; it must match the scoreboard.
    task automatic step();
        logic [31:0] e;
        if (fifo_wvalid === 1'b1 && fifo_wready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", fifo_wdata, 32'hxxxxxxxx);
            end else begin
                e = exp_q.pop_front();
                chk("fifo_write", fifo_wdata, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cmds();
        in_en = 0; load = 0; push_req = 0;
    endtask

    task automatic do_in(input logic [31:0] d, input logic [5:0] n, input logic dir);
        idle_cmds();
        data_in = d; in_count = n; shiftdir = dir; in_en = 1;
        step();
        in_en = 0;
    endtask

    task automatic do_load(input logic [31:0] d);
        idle_cmds();
        load_data = d; load = 1;
        step();
        load = 0;
    endtask

    initial begin
        rst = 1; data_in = 0; in_en = 0; in_count = 0; shiftdir = 0; load = 0; load_data = 0;
        push_req = 0; push_block = 0; autopush = 0; push_thresh = 0; fifo_wready = 0;
        step(); step();
        chk("rst_isr", isr, 0);
        chk("rst_count", {26'd0, isr_count}, 0);
        chk("rst_wvalid", {31'd0, fifo_wvalid}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_wdata", fifo_wdata, 0);
        chk("rst_dropped", {31'd0, push_dropped}, 0);
        rst = 0;
        step();

        do_in(32'h5, 6'd4, 1'b0);
        do_in(32'h3, 6'd4, 1'b0);
        chk("left_isr", isr, 32'h53);
        chk("left_count", {26'd0, isr_count}, 8);

        do_load(32'h0);
        do_in(32'hA, 6'd4, 1'b1);
        chk("right_isr", isr, 32'hA000_0000);
        chk("right_count", {26'd0, isr_count}, 4);

        data_in = 32'hFFFF; in_count = 6'd8; shiftdir = 0; in_en = 1;
        load_data = 32'h1234; load = 1;
        step();
        idle_cmds();
        chk("collide_isr", isr, 32'h1234);
        chk("collide_count", {26'd0, isr_count}, 0);

        do_in(32'hCAFE_F00D, 6'd0, 1'b0);
        chk("in32_isr", isr, 32'hCAFE_F00D);
        chk("in32_count", {26'd0, isr_count}, 32);
        do_in(32'h1, 6'd4, 1'b0);
        chk("sat_isr", isr, 32'hAFEF_00D1);
        chk("sat_count", {26'd0, isr_count}, 32);
        do_in(32'h1122_3344, 6'd40, 1'b1);
        chk("n40_isr", isr, 32'h1122_3344);

        push_block = 1; push_req = 1; fifo_wready = 0;
        exp_q.push_back(32'h1122_3344);
        step();
        push_req = 0;
        chk("bpush_wvalid", {31'd0, fifo_wvalid}, 1);
        chk("bpush_stall", {31'd0, stall}, 1);
        chk("bpush_wdata", fifo_wdata, 32'h1122_3344);
        chk("bpush_isr", isr, 0);
        chk("bpush_count", {26'd0, isr_count}, 0);
        data_in = 32'hF; in_count = 6'd4; in_en = 1;
        step();
        in_en = 0;
        chk("push_ignore_isr", isr, 0);
        chk("push_ignore_stall", {31'd0, stall}, 1);
        fifo_wready = 1;
        step();
        chk("bpush_done_wvalid", {31'd0, fifo_wvalid}, 0);
        chk("bpush_done_stall", {31'd0, stall}, 0);
        chk("idle_wdata_hold", fifo_wdata, 32'h1122_3344);

        fifo_wready = 0;
        do_load(32'hDEAD_BEEF);
        push_block = 0; push_req = 1;
        step();
        push_req = 0;
        chk("drop_isr", isr, 0);
        chk("drop_pulse", {31'd0, push_dropped}, 1);
        chk("drop_wvalid", {31'd0, fifo_wvalid}, 0);
        step();
        chk("drop_pulse_end", {31'd0, push_dropped}, 0);

        autopush = 1; push_thresh = 6'd8; fifo_wready = 0;
        do_in(32'h1, 6'd4, 1'b0);
`ifdef ISR_AUTOPUSH_EN
        exp_q.push_back(32'h12);
        do_in(32'h2, 6'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("ap_wvalid", {31'd0, fifo_wvalid}, 1);
            chk("ap_stall", {31'd0, stall}, 1);
            chk("ap_wdata", fifo_wdata, 32'h12);
            if (i < 2) step();
        end
        fifo_wready = 1;
        step();
        chk("ap_done_wvalid", {31'd0, fifo_wvalid}, 0);
        chk("ap_done_isr", isr, 0);
`else
        do_in(32'h2, 6'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("noap_wvalid", {31'd0, fifo_wvalid}, 0);
            step();
        end
        chk("noap_isr", isr, 32'h12);
        chk("noap_count", {26'd0, isr_count}, 8);
`endif
        autopush = 0;

        do_load(32'h5555_AAAA);
        fifo_wready = 0; push_block = 1; push_req = 1;
        exp_q.push_back(32'h5555_AAAA);
        step();
        push_req = 0;
        chk("rpush_wvalid", {31'd0, fifo_wvalid}, 1);
        rst = 1;
        #1;
        void'(exp_q.pop_back());
        chk("rpush_wvalid_rst", {31'd0, fifo_wvalid}, 0);
        chk("rpush_stall_rst", {31'd0, stall}, 0);
        chk("rpush_wdata_rst", fifo_wdata, 0);
        chk("rpush_isr_rst", isr, 0);
        step();
        rst = 0; fifo_wready = 1;
        for (int i = 0; i < 4; i++) step();
        chk("rpush_after_wvalid", {31'd0, fifo_wvalid}, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_shift_register.md
INPUT_SHIFT_REGISTER -- requirements
Module: input_shift_register

Interface
REQ-001 SHALL have `clk`, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have `rst`, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have `data_in`, input, 32 bits: IN source bits, taken from the LSBs.
REQ-004 SHALL have `in_en`, input, 1 bit: IN strobe.
REQ-005 SHALL have `in_count`, input, 6 bits: bits to shift in; 0 and values above 32 mean 32.
REQ-006 SHALL have `shiftdir`, input, 1 bit: 0 = left, 1 = right.
REQ-007 SHALL have `load`, input, 1 bit, and `load_data`, input, 32 bits: MOV into the ISR.
REQ-008 SHALL have `push_req`, input, 1 bit: explicit PUSH.
REQ-009 SHALL have `push_block`, input, 1 bit: 1 = blocking PUSH.
REQ-010 SHALL have `autopush`, input, 1 bit: autopush enable.
REQ-011 SHALL have `push_thresh`, input, 6 bits: autopush threshold; 0 and values above 32 mean 32.
REQ-012 SHALL have `isr`, output, 32 bits: current ISR contents.
REQ-013 SHALL have `isr_count`, output, 6 bits: valid bit count, 0..32.
REQ-014 SHALL have `fifo_wdata`, output, 32 bits: RX FIFO write data.
REQ-015 SHALL have `fifo_wvalid`, output, 1 bit: RX FIFO write valid.
REQ-016 SHALL have `fifo_wready`, input, 1 bit: RX FIFO not full.
REQ-017 SHALL have `stall`, output, 1 bit: instruction stalled.
REQ-018 SHALL have `push_dropped`, output, 1 bit: one-cycle pulse when a push is lost.

Function
REQ-019 SHALL implement a two-state FSM: IDLE and PUSH.
REQ-020 In IDLE, commands SHALL be prioritised `load` > `push_req` > `in_en`; lower-priority commands in the same cycle are ignored.
REQ-021 `load` SHALL set `isr` = `load_data` and `isr_count` = 0 on the next edge.
REQ-022 An IN left shift (n bits) SHALL produce `isr` = (`isr` << n) | `data_in`[n-1:0].
REQ-023 An IN right shift (n bits) SHALL produce `isr` = (`isr` >> n) | (`data_in`[n-1:0] << (32-n)).
REQ-024 For n = 32, both shift directions SHALL produce `isr` = `data_in`.
REQ-025 After an IN, `isr_count` SHALL be min(`isr_count` + n, 32), saturating.
REQ-026 Autopush SHALL trigger when `autopush` = 1 and the post-IN count is >= the threshold.
REQ-027 On autopush, the post-IN value SHALL go into the push buffer, `isr` and `isr_count` SHALL clear, and the FSM SHALL enter PUSH, all on the same edge.
REQ-028 On `push_req` with `push_block` = 1, or with `fifo_wready` = 1: the push buffer SHALL take `isr`, `isr`/`isr_count` SHALL clear, and the FSM SHALL enter PUSH.
REQ-029 On `push_req` with `push_block` = 0 and `fifo_wready` = 0: `isr`/`isr_count` SHALL clear, `push_dropped` SHALL pulse next cycle, and the FSM SHALL stay in IDLE.
REQ-030 In PUSH, `fifo_wvalid` SHALL be 1, `fifo_wdata` SHALL equal the push buffer, and `stall` SHALL be 1.
REQ-031 In PUSH, all commands SHALL be ignored.
REQ-032 The FSM SHALL return to IDLE on the edge where `fifo_wvalid` and `fifo_wready` are both 1.
REQ-033 Push latency SHALL be: `fifo_wvalid` rises 1 cycle after the triggering command, minimum 1 cycle in PUSH.
REQ-034 In IDLE, `fifo_wvalid` = 0, `stall` = 0, and `fifo_wdata` holds its last value.
REQ-035 A 32-bit IN with an empty ISR SHALL fill `isr_count` to 32 in one cycle.

Reset
REQ-036 `rst` SHALL asynchronously force IDLE and set `isr`, `isr_count`, the push buffer, `fifo_wdata`, `fifo_wvalid`, `stall` and `push_dropped` to 0.
REQ-037 Reset asserted while in PUSH SHALL discard the pending word, with no FIFO write.

Configuration
REQ-038 The macro ISR_AUTOPUSH_EN SHALL control autopush.
REQ-039 With ISR_AUTOPUSH_EN defined, REQ-026/027 SHALL apply.
REQ-040 Without ISR_AUTOPUSH_EN, `autopush` and `push_thresh` SHALL be ignored and the threshold logic SHALL be absent.
REQ-041 Without ISR_AUTOPUSH_EN, IN SHALL only shift and count, and `isr_count` SHALL saturate at 32.

Verification
REQ-042 Left shifts: reset, then IN `data_in`=0x5, n=4, then 0x3, n=4 -> `isr`=0x53, `isr_count`=8.
REQ-043 Right shift: IN `data_in`=0xA, n=4, `shiftdir`=1 from empty -> `isr`=0xA0000000, `isr_count`=4.
REQ-044 Autopush stall: `autopush`=1, `push_thresh`=8, two IN of 4 bits (0x1, 0x2), `fifo_wready`=0 for 3 cycles -> `fifo_wvalid`=1 and `stall`=1 throughout with `fifo_wdata`=0x12, then return to IDLE with `isr`=0.
REQ-045 Non-blocking drop: `push_req`, `push_block`=0, `fifo_wready`=0, `isr`=0xDEADBEEF -> `push_dropped` pulse, `isr`=0, no write.
REQ-046 Reset in PUSH: assert `rst` while in PUSH with `fifo_wready`=0 -> all outputs 0 immediately, no write after release.
REQ-047 Command collision: `load` 0x1234 with `in_en` in the same cycle -> `isr`=0x1234, `isr_count`=0; build without ISR_AUTOPUSH_EN -> REQ-044 produces no push.
